// File: rtl/vigna_clint_pkg.sv
// Shared CLINT register offsets, reset values, handshake states
// and the byte-strobe merge helper.
package vigna_clint_pkg;

  localparam logic [5:0] CLINT_MSIP        = 6'h00;
  localparam logic [5:0] CLINT_MTIMECMP_LO = 6'h04;
  localparam logic [5:0] CLINT_MTIMECMP_HI = 6'h08;
  localparam logic [5:0] CLINT_MTIME_LO    = 6'h0C;
  localparam logic [5:0] CLINT_MTIME_HI    = 6'h10;
  localparam logic [5:0] CLINT_PRESC       = 6'h14;

  localparam logic [63:0] CLINT_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACK,
    S_WAIT_LOW
  } clint_state_e;

  function automatic logic [31:0] merge_wstrb(
    input logic [31:0] old,
    input logic [31:0] wdata,
    input logic [3:0]  wstrb
  );
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = wstrb[i] ? wdata[8*i +: 8] : old[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/vigna_clint_timer.sv
// Prescaler and 64-bit mtime; byte writes to either half, and
// any mtime write suppresses that cycle's increment.
// Ports: clk/resetn, lo_we/hi_we/presc_we + wdata/wstrb in;
//        mtime and presc out.
module vigna_clint_timer
  import vigna_clint_pkg::*;
#(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               lo_we,
  input  logic               hi_we,
  input  logic               presc_we,
  input  logic [31:0]        wdata,
  input  logic [3:0]         wstrb,
  output logic [63:0]        mtime,
  output logic [PRESC_W-1:0] presc
);

  logic [63:0]        mtime_q, mtime_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic               tick;

  always_comb begin
    tick    = (cnt_q == presc_q);
    cnt_d   = tick ? '0 : cnt_q + PRESC_W'(1);
    presc_d = presc_q;
    mtime_d = mtime_q;
    if (presc_we) begin
      presc_d = PRESC_W'(merge_wstrb(32'(presc_q), wdata, wstrb));
      cnt_d   = '0;
    end
    if (lo_we || hi_we) begin
      if (lo_we) begin
        mtime_d[31:0] = merge_wstrb(mtime_q[31:0], wdata, wstrb);
      end
      if (hi_we) begin
        mtime_d[63:32] = merge_wstrb(mtime_q[63:32], wdata, wstrb);
      end
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mtime_q <= '0;
      presc_q <= '0;
      cnt_q   <= '0;
    end else begin
      mtime_q <= mtime_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mtime = mtime_q;
  assign presc = presc_q;

endmodule

// File: rtl/vigna_clint.sv
// Core-local interruptor: bus responder, msip, mtimecmp, irqs.
// Ports: clk/resetn, d_* responder bus, timer_irq, soft_irq.
module vigna_clint
  import vigna_clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          PRESC_W   = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic        timer_irq,
  output logic        soft_irq
);

  clint_state_e state_q, state_d;

  logic        msip_q, msip_d;
  logic [63:0] cmp_q, cmp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        soft_q, soft_d;
  logic        tirq_q, tirq_d;

  logic [63:0]        mtime;
  logic [PRESC_W-1:0] presc;

  logic       hit, accept, wr, rd;
  logic [5:0] off;
  logic       sel_msip, sel_cmp_lo, sel_cmp_hi;
  logic       sel_mt_lo, sel_mt_hi, sel_presc;
  logic       unused_addr;

  assign unused_addr = ^d_addr[1:0];

  assign hit = d_valid && (d_addr[31:6] == BASE_ADDR[31:6]);
  assign off = {d_addr[5:2], 2'b00};

  assign sel_msip   = (off == CLINT_MSIP);
  assign sel_cmp_lo = (off == CLINT_MTIMECMP_LO);
  assign sel_cmp_hi = (off == CLINT_MTIMECMP_HI);
  assign sel_mt_lo  = (off == CLINT_MTIME_LO);
  assign sel_mt_hi  = (off == CLINT_MTIME_HI);
  assign sel_presc  = (off == CLINT_PRESC);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (hit) begin
          accept  = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK:      state_d = S_WAIT_LOW;
      S_WAIT_LOW: if (!d_valid) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  assign wr = accept && (|d_wstrb);
  assign rd = accept && !(|d_wstrb);

  always_comb begin
    msip_d  = msip_q;
    cmp_d   = cmp_q;
    rdata_d = '0;
    if (wr && sel_msip && d_wstrb[0]) begin
      msip_d = d_wdata[0];
    end
    if (wr && sel_cmp_lo) begin
      cmp_d[31:0] = merge_wstrb(cmp_q[31:0], d_wdata, d_wstrb);
    end
    if (wr && sel_cmp_hi) begin
      cmp_d[63:32] = merge_wstrb(cmp_q[63:32], d_wdata, d_wstrb);
    end
    if (rd) begin
      unique case (1'b1)
        sel_msip:   rdata_d = {31'd0, msip_q};
        sel_cmp_lo: rdata_d = cmp_q[31:0];
        sel_cmp_hi: rdata_d = cmp_q[63:32];
        sel_mt_lo:  rdata_d = mtime[31:0];
        sel_mt_hi:  rdata_d = mtime[63:32];
        sel_presc:  rdata_d = 32'(presc);
        default:    rdata_d = '0;
      endcase
    end
    soft_d = msip_q;
    // compares the registered (post-update) mtime, so the irq
    // trails the condition by one cycle
    tirq_d = (mtime >= cmp_q);
  end

  vigna_clint_timer #(
    .PRESC_W (PRESC_W)
  ) u_timer (
    .clk      (clk),
    .resetn   (resetn),
    .lo_we    (wr && sel_mt_lo),
    .hi_we    (wr && sel_mt_hi),
    .presc_we (wr && sel_presc),
    .wdata    (d_wdata),
    .wstrb    (d_wstrb),
    .mtime    (mtime),
    .presc    (presc)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      msip_q  <= 1'b0;
      cmp_q   <= CLINT_MTIMECMP_RST;
      rdata_q <= '0;
      soft_q  <= 1'b0;
      tirq_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      msip_q  <= msip_d;
      cmp_q   <= cmp_d;
      rdata_q <= rdata_d;
      soft_q  <= soft_d;
      tirq_q  <= tirq_d;
    end
  end

  assign d_ready   = (state_q == S_ACK);
  assign d_rdata   = rdata_q;
  assign timer_irq = tirq_q;
  assign soft_irq  = soft_q;

endmodule
